// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES decryption datapath stages:
//   state_t    - IDLE / BUSY / DONE handshake FSM encoding
//   GF_POLY    - low byte of the AES field polynomial x^8+x^4+x^3+x+1
//   BYTE_W     - bits per state byte
//   COL_W      - bits per state column (four bytes)
//   COL_IDX_W  - width of a column index (four columns)
//   xtime()    - multiply a field element by x (i.e. by 02) in GF(2^8)
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] GF_POLY   = 8'h1b;
  localparam int         BYTE_W    = 8;
  localparam int         COL_W     = 32;
  localparam int         COL_IDX_W = 2;

  // Shift left by one; if the x^7 term overflowed, fold it back with the
  // reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_inv_mix_column_word.sv
// -----------------------------------------------------------------------------
// aes_inv_mix_column_word
// Purely combinational InvMixColumns on a single 32-bit state column.
//   col_in   [0:31]  input column; byte k = bits 8k..8k+7, bit 8k is the MSB
//   col_out  [0:31]  transformed column, same byte layout
// Each byte is multiplied by 09/0b/0d/0e using only xtime chains:
//   09 = x8^x1, 0b = x8^x2^x1, 0d = x8^x4^x1, 0e = x8^x4^x2.
// -----------------------------------------------------------------------------
module aes_inv_mix_column_word
  import aes_pkg::*;
(
  input  logic [0:COL_W-1] col_in,
  output logic [0:COL_W-1] col_out
);

  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  for (genvar i = 0; i < 4; i++) begin : g_byte
    logic [7:0] b, x2, x4, x8;

    assign b  = col_in[BYTE_W*i +: BYTE_W];
    assign x2 = xtime(b);
    assign x4 = xtime(x2);
    assign x8 = xtime(x4);

    assign m9[i] = x8 ^ b;
    assign mb[i] = x8 ^ x2 ^ b;
    assign md[i] = x8 ^ x4 ^ b;
    assign me[i] = x8 ^ x4 ^ x2;
  end

  // Rows of the inverse circulant matrix {0e 0b 0d 09}.
  assign col_out[0:7]   = me[0] ^ mb[1] ^ md[2] ^ m9[3];
  assign col_out[8:15]  = m9[0] ^ me[1] ^ mb[2] ^ md[3];
  assign col_out[16:23] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
  assign col_out[24:31] = mb[0] ^ md[1] ^ m9[2] ^ me[3];

endmodule

// File: rtl/aes_inv_mix_columns.sv
// -----------------------------------------------------------------------------
// aes_inv_mix_columns
// Iterative InvMixColumns stage for the AES-256 decryption round. A 128-bit
// state is captured over a valid/ready handshake, transformed in place
// COLS_PER_CYCLE columns per clock, then held until the downstream stage
// accepts it.
//   COLS_PER_CYCLE  columns per BUSY cycle; legal values 1, 2, 4
//                   (compute latency 4/COLS_PER_CYCLE cycles)
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   in_data  [0:127] input state; byte k = bits 8k..8k+7 (bit 8k MSB),
//                    column c = bytes 4c..4c+3
//   in_valid        in_data is valid
//   in_ready        block can take a state this cycle (combinational)
//   out_data [0:127] working register; meaningful only while out_valid
//   out_valid       out_data holds a finished result (registered)
//   out_accept      downstream takes out_data this cycle
// -----------------------------------------------------------------------------
module aes_inv_mix_columns
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [0:127] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [0:127] out_data,
  output logic         out_valid,
  input  logic         out_accept
);

  // Column step as a 3-bit quantity so the carry out of the 2-bit column
  // counter marks the cycle that finishes column 3 (legal steps all land on 4).
  localparam logic [COL_IDX_W:0] STEP = (COL_IDX_W + 1)'(COLS_PER_CYCLE);

  state_t                 state;
  logic [COL_IDX_W-1:0]   col;
  logic [0:127]           work;
  logic [0:127]           work_next;
  logic [COL_IDX_W:0]     col_sum;

  logic [COL_IDX_W-1:0]   col_idx [COLS_PER_CYCLE];
  logic [0:COL_W-1]       col_in  [COLS_PER_CYCLE];
  logic [0:COL_W-1]       col_out [COLS_PER_CYCLE];

  assign col_sum = {1'b0, col} + STEP;

  // One single-column transformer per lane, each reading the column the
  // counter currently points at (plus its lane offset).
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    assign col_idx[g] = col + COL_IDX_W'(g);
    assign col_in[g]  = work[{col_idx[g], 5'd0} +: COL_W];

    aes_inv_mix_column_word u_word (
      .col_in  (col_in[g]),
      .col_out (col_out[g])
    );
  end

  // NOTE: every always_comb output gets a full default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    work_next = work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      work_next[{col_idx[g], 5'd0} +: COL_W] = col_out[g];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: the working register is reset too, because it is visible on
  // out_data and must read as zero coming out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      col       <= '0;
      work      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            col   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          work <= work_next;
          col  <= col_sum[COL_IDX_W-1:0];
          if (col_sum[COL_IDX_W]) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // Accept with a waiting input restarts immediately; otherwise the
          // result is simply held until the downstream stage takes it.
          if (out_accept) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              work  <= in_data;
              col   <= '0;
              state <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = (state == IDLE) | ((state == DONE) & out_accept);
  assign out_data = work;

endmodule

// File: tb/tb_aes_inv_mix_columns.sv
// -----------------------------------------------------------------------------
// tb_aes_inv_mix_columns
// Self-checking bench for aes_inv_mix_columns. Three instances run side by
// side with COLS_PER_CYCLE = 1, 2, 4 (lane index 0, 1, 2). Expected results
// come from a matrix-times-vector model over GF(2^8) using long-hand
// polynomial multiplication and reduction by 0x11b.
// -----------------------------------------------------------------------------
module tb_aes_inv_mix_columns;

  localparam int NBLK = 100;

  logic         clk;
  logic         reset;
  logic [0:127] in_data    [3];
  logic         in_valid   [3];
  logic         in_ready   [3];
  logic [0:127] out_data   [3];
  logic         out_valid  [3];
  logic         out_accept [3];

  int checks;
  int failures;

  aes_inv_mix_columns #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_accept(out_accept[0])
  );

  aes_inv_mix_columns #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_accept(out_accept[1])
  );

  aes_inv_mix_columns #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .out_data(out_data[2]), .out_valid(out_valid[2]), .out_accept(out_accept[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- model ---
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (prod[i]) prod ^= (16'h11b << (i - 8));
    return prod[7:0];
  endfunction

  // Circulant matrix whose first row is coefs (MSB byte first) applied to
  // every column of the state.
  function automatic logic [0:127] mat_apply(input logic [0:127] s,
                                             input logic [31:0]  coefs);
    logic [0:127] o;
    logic [7:0]   acc;
    logic [7:0]   cf;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) begin
          cf  = coefs[8*(3 - ((j - r) & 3)) +: 8];
          acc ^= gmul(cf, s[8*(4*c + j) +: 8]);
        end
        o[8*(4*c + r) +: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] inv_ref(input logic [0:127] s);
    return mat_apply(s, 32'h0e0b0d09);
  endfunction

  function automatic logic [0:127] fwd_ref(input logic [0:127] s);
    return mat_apply(s, 32'h02030101);
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic int lat_of(input int idx);
    return 4 / (1 << idx);
  endfunction

  // -------------------------------------------------------------- drivers ---
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one state for exactly one edge; caller ensures in_ready is high.
  task automatic send(input int idx, input logic [0:127] d);
    in_data[idx]  = d;
    in_valid[idx] = 1'b1;
    tick();
    in_valid[idx] = 1'b0;
  endtask

  // Cycles from the handshake edge until out_valid is seen; -1 on timeout.
  task automatic wait_valid(input int idx, output int cnt);
    cnt = 0;
    while (out_valid[idx] !== 1'b1 && cnt <= 20) begin
      tick();
      cnt++;
    end
    if (cnt > 20) cnt = -1;
  endtask

  task automatic accept(input int idx);
    out_accept[idx] = 1'b1;
    tick();
    out_accept[idx] = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests ---
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid[i] !== 1'b0) begin
        failures++;
        $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_valid[i]);
      end
      checks++;
      if (in_ready[i] !== 1'b1) begin
        failures++;
        $display("FAIL reset_in_ready[%0d]: got %b want 1", i, in_ready[i]);
      end
      checks++;
      if (out_data[i] !== 128'h0) begin
        failures++;
        $display("FAIL reset_out_data[%0d]: got %h want 0", i, out_data[i]);
      end
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_column();
    logic [0:127] d, exp;
    int cnt;
    d   = 128'h8e4da1bc_01010101_01010101_01010101;
    exp = 128'hdb135345_01010101_01010101_01010101;
    send(0, d);
    wait_valid(0, cnt);
    checks++;
    if (cnt !== 4) begin
      failures++;
      $display("FAIL single_col_latency: got %0d want 4", cnt);
    end
    checks++;
    if (out_data[0] !== exp) begin
      failures++;
      $display("FAIL single_col_data: got %h want %h", out_data[0], exp);
    end
    accept(0);
  endtask

  task automatic test_full_state();
    logic [0:127] d, exp;
    int cnt;
    d   = 128'h9fdc589d_c6c6c6c6_d5d5d7d6_4d7ebdf8;
    exp = 128'hf20a225c_c6c6c6c6_d4d4d4d5_2d26314c;
    for (int i = 0; i < 3; i++) begin
      send(i, d);
      wait_valid(i, cnt);
      checks++;
      if (cnt !== lat_of(i)) begin
        failures++;
        $display("FAIL full_latency[%0d]: got %0d want %0d", i, cnt, lat_of(i));
      end
      checks++;
      if (out_data[i] !== exp) begin
        failures++;
        $display("FAIL full_data[%0d]: got %h want %h", i, out_data[i], exp);
      end
      accept(i);
    end
  endtask

  task automatic test_backpressure();
    logic [0:127] a, b, exp_a;
    int cnt;
    a = rand128();
    b = rand128();
    exp_a = inv_ref(a);
    send(0, a);
    wait_valid(0, cnt);
    in_data[0]    = b;
    in_valid[0]   = 1'b1;
    out_accept[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (out_valid[0] !== 1'b1) begin
        failures++;
        $display("FAIL bp_out_valid cycle %0d: got %b want 1", k, out_valid[0]);
      end
      checks++;
      if (out_data[0] !== exp_a) begin
        failures++;
        $display("FAIL bp_out_data cycle %0d: got %h want %h", k, out_data[0], exp_a);
      end
      checks++;
      if (in_ready[0] !== 1'b0) begin
        failures++;
        $display("FAIL bp_in_ready cycle %0d: got %b want 0", k, in_ready[0]);
      end
      tick();
    end
    out_accept[0] = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_on_accept: got %b want 1", in_ready[0]);
    end
    tick();
    out_accept[0] = 1'b0;
    in_valid[0]   = 1'b0;
    checks++;
    if (out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_valid_drop: got %b want 0", out_valid[0]);
    end
    wait_valid(0, cnt);
    checks++;
    if (cnt !== 4) begin
      failures++;
      $display("FAIL bp_next_latency: got %0d want 4", cnt);
    end
    checks++;
    if (out_data[0] !== inv_ref(b)) begin
      failures++;
      $display("FAIL bp_next_data: got %h want %h", out_data[0], inv_ref(b));
    end
    accept(0);
  endtask

  task automatic test_back_to_back(input int idx);
    logic [0:127] exp_q [$];
    logic [0:127] d, e;
    int  sent, recv, cyc, last_out, per;
    logic hs;
    sent = 0; recv = 0; cyc = 0; last_out = -1;
    per  = lat_of(idx) + 1;
    d = rand128();
    in_data[idx]    = d;
    in_valid[idx]   = 1'b1;
    out_accept[idx] = 1'b1;
    while (recv < NBLK && cyc < NBLK * per + 50) begin
      hs = in_valid[idx] & in_ready[idx];
      if (out_valid[idx] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_extra[%0d]: unexpected output %h", idx, out_data[idx]);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (out_data[idx] !== e) begin
            failures++;
            $display("FAIL stream_data[%0d] blk %0d: got %h want %h", idx, recv, out_data[idx], e);
          end
        end
        if (last_out >= 0) begin
          checks++;
          if (cyc - last_out !== per) begin
            failures++;
            $display("FAIL stream_period[%0d] blk %0d: got %0d want %0d", idx, recv, cyc - last_out, per);
          end
        end
        last_out = cyc;
        recv++;
      end
      tick();
      cyc++;
      if (hs) begin
        exp_q.push_back(inv_ref(d));
        sent++;
        if (sent < NBLK) begin
          d = rand128();
          in_data[idx] = d;
        end else begin
          in_valid[idx] = 1'b0;
        end
      end
    end
    in_valid[idx]   = 1'b0;
    out_accept[idx] = 1'b0;
    checks++;
    if (recv !== NBLK) begin
      failures++;
      $display("FAIL stream_count[%0d]: got %0d want %0d", idx, recv, NBLK);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL stream_leftover[%0d]: got %0d want 0", idx, exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    logic [0:127] d;
    int cnt;
    // Lane 1 parked in DONE, lane 0 two columns into its block.
    send(1, rand128());
    wait_valid(1, cnt);
    send(0, rand128());
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy_out_valid: got %b want 0", out_valid[0]);
    end
    checks++;
    if (in_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL rst_busy_in_ready: got %b want 1", in_ready[0]);
    end
    checks++;
    if (out_valid[1] !== 1'b0) begin
      failures++;
      $display("FAIL rst_done_out_valid: got %b want 0", out_valid[1]);
    end
    tick();
    reset = 1'b1;
    repeat (6) begin
      tick();
      checks++;
      if (out_valid[0] !== 1'b0) begin
        failures++;
        $display("FAIL rst_no_stale_output: got %b want 0", out_valid[0]);
      end
    end
    d = rand128();
    send(0, d);
    wait_valid(0, cnt);
    checks++;
    if (cnt !== 4) begin
      failures++;
      $display("FAIL rst_after_latency: got %0d want 4", cnt);
    end
    checks++;
    if (out_data[0] !== inv_ref(d)) begin
      failures++;
      $display("FAIL rst_after_data: got %h want %h", out_data[0], inv_ref(d));
    end
    accept(0);
  endtask

  task automatic test_round_trip();
    logic [0:127] s;
    int cnt;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        s = rand128();
        send(i, fwd_ref(s));
        wait_valid(i, cnt);
        checks++;
        if (out_data[i] !== s) begin
          failures++;
          $display("FAIL round_trip[%0d.%0d]: got %h want %h", i, k, out_data[i], s);
        end
        accept(i);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data[i]    = '0;
      in_valid[i]   = 1'b0;
      out_accept[i] = 1'b0;
    end
    test_reset();
    test_single_column();
    test_full_state();
    test_backpressure();
    for (int i = 0; i < 3; i++) test_back_to_back(i);
    test_reset_mid_busy();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
